mult_div_unit: RTL and testbench

//  E-stage multiply/divide unit for the 5-stage MIPS core. Executes mult/multu/div/divu with fixed

---
 rtl/mult_div_unit_pkg.sv | 56 +++++
 rtl/mult_div_unit_counter.sv | 39 +++
 rtl/mult_div_unit.sv | 162 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared MDU opcode encodings and the divide helper used by
// mult_div_unit.
//   MDU_* opcodes : 4-bit E-stage MDU operation codes (MDU_NONE = 0).
//   div_result()  : {remainder, quotient} for signed/unsigned 32-bit divide.
package mult_div_unit_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;
  localparam logic [3:0] MDU_MADD  = 4'd9;
  localparam logic [3:0] MDU_MADDU = 4'd10;
  localparam logic [3:0] MDU_MSUB  = 4'd11;
  localparam logic [3:0] MDU_MSUBU = 4'd12;

  // Returns {remainder, quotient}. Signed: quotient truncates toward zero and
  // the remainder takes the dividend's sign. The one signed overflow case
  // (-2^31 / -1) is pinned explicitly instead of relying on the operator.
  // A zero divisor yields zero; the caller suppresses the commit in that case.
  function automatic logic [63:0] div_result(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sgn);
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic [31:0]        q;
    logic [31:0]        r;
    sq = '0;
    sr = '0;
    q  = '0;
    r  = '0;
    if (b == '0) begin
      q = '0;
      r = '0;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = '0;
      end else begin
        sq = $signed(a) / $signed(b);
        sr = $signed(a) % $signed(b);
        q  = sq;
        r  = sr;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

endpackage

// File: rtl/mult_div_unit_counter.sv
// mult_div_unit_counter: fixed-latency down counter that models the iterative
// multiply/divide datapath.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : load load_val this edge (only issued while the count is 0)
//   load_val     : latency in cycles
//   last         : count is 1, i.e. the next edge is the final busy edge
module mult_div_unit_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit. Runs mult/multu/div/divu with a
// fixed multi-cycle latency, serves mthi/mtlo/mfhi/mflo and owns HI/LO.
// Defining MDU_MADD_EN adds madd/maddu/msub/msubu (accumulate into {hi,lo}
// with MULT_CYCLES latency); otherwise those opcodes behave as MDU_NONE.
//   clk, reset_n : clock, asynchronous active-low reset
//   md_op        : MDU opcode of the E-stage instruction
//   rs_val       : operand A (dividend / multiplicand / mthi,mtlo source)
//   rt_val       : operand B (divisor / multiplier)
//   req          : exception taken this cycle; the E instruction is flushed
//   start        : comb, a multi-cycle op is accepted this cycle
//   busy         : registered, high for exactly N cycles after a start
//   hi, lo       : architectural HI/LO
//   mf_result    : comb, hi for mfhi, lo for mflo, else 0
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_result
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] shadow_hi_q, shadow_hi_d;
  logic [31:0] shadow_lo_q, shadow_lo_d;
  logic        shadow_wr_q, shadow_wr_d;

  logic              op_mul;
  logic              op_div;
  logic              op_acc;
  logic              commit;
  logic              cnt_last;
  logic [CNT_W-1:0]  cnt_load_val;
  logic signed [63:0] prod_s;
  logic [63:0]       prod_u;
  logic [63:0]       result;
`ifdef MDU_MADD_EN
  logic [63:0]       acc;
`endif

  always_comb begin
    op_mul = (md_op == MDU_MULT) || (md_op == MDU_MULTU);
    op_div = (md_op == MDU_DIV)  || (md_op == MDU_DIVU);
`ifdef MDU_MADD_EN
    op_acc = (md_op == MDU_MADD) || (md_op == MDU_MADDU) ||
             (md_op == MDU_MSUB) || (md_op == MDU_MSUBU);
`else
    op_acc = 1'b0;
`endif
  end

  // Ops arriving while busy are ignored: the hazard unit never sends them.
  assign start = (op_mul || op_div || op_acc) && !req && !busy_q;

  assign cnt_load_val = op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  mult_div_unit_counter #(
    .W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (start),
    .load_val (cnt_load_val),
    .last     (cnt_last)
  );

  always_comb begin
    prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    prod_u = {32'b0, rs_val} * {32'b0, rt_val};
`ifdef MDU_MADD_EN
    acc    = {hi_q, lo_q};
`endif
    result = '0;
    case (md_op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV:   result = div_result(rs_val, rt_val, 1'b1);
      MDU_DIVU:  result = div_result(rs_val, rt_val, 1'b0);
`ifdef MDU_MADD_EN
      MDU_MADD:  result = acc + prod_s;
      MDU_MADDU: result = acc + prod_u;
      MDU_MSUB:  result = acc - prod_s;
      MDU_MSUBU: result = acc - prod_u;
`endif
      default:   result = '0;
    endcase
  end

  // The result is captured at start; the commit edge copies it to HI/LO
  // unless the op was a divide by zero.
  assign commit = busy_q && cnt_last;

  always_comb begin
    busy_d      = busy_q;
    shadow_hi_d = shadow_hi_q;
    shadow_lo_d = shadow_lo_q;
    shadow_wr_d = shadow_wr_q;
    hi_d        = hi_q;
    lo_d        = lo_q;

    if (start) begin
      busy_d      = 1'b1;
      shadow_hi_d = result[63:32];
      shadow_lo_d = result[31:0];
      shadow_wr_d = !(op_div && (rt_val == '0));
    end else if (commit) begin
      busy_d = 1'b0;
    end

    if (commit && shadow_wr_q) begin
      hi_d = shadow_hi_q;
      lo_d = shadow_lo_q;
    end else if (!busy_q && !req) begin
      if (md_op == MDU_MTHI) hi_d = rs_val;
      if (md_op == MDU_MTLO) lo_d = rs_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      shadow_hi_q <= '0;
      shadow_lo_q <= '0;
      shadow_wr_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      shadow_hi_q <= shadow_hi_d;
      shadow_lo_q <= shadow_lo_d;
      shadow_wr_q <= shadow_wr_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    mf_result = '0;
    if (md_op == MDU_MFHI) mf_result = hi_q;
    else if (md_op == MDU_MFLO) mf_result = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit. A cycle-level
// behavioural model (plain 64-bit integer arithmetic plus a remaining-cycles
// count) predicts start/busy/hi/lo/mf_result, compared on every falling edge.
// Directed cases carry hand-computed expectations; a random phase follows.
// Build with +define+MDU_MADD_EN to cover the accumulate opcodes.
module tb_mult_div_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  md_op = OP_NONE;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        req = 1'b0;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_result;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .req       (req),
    .start     (start),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .mf_result (mf_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic model_starts(input logic [3:0] op);
    if (op >= OP_MULT && op <= OP_DIVU) return 1'b1;
`ifdef MDU_MADD_EN
    if (op >= OP_MADD && op <= OP_MSUBU) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // {hi,lo} produced by a multi-cycle op; ok=0 means HI/LO stay unchanged.
  function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] h, input logic [31:0] l,
                                   output logic [63:0] res, output logic ok);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    ok  = 1'b1;
    case (op)
      OP_MULT:  res = sa * sb;
      OP_MULTU: res = ua * ub;
      OP_DIV:   if (b == 0) ok = 1'b0;
                else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      OP_DIVU:  if (b == 0) ok = 1'b0;
                else begin q = longint'(ua / ub); r = longint'(ua % ub); res = {r[31:0], q[31:0]}; end
      OP_MADD:  res = {h, l} + sa * sb;
      OP_MADDU: res = {h, l} + ua * ub;
      OP_MSUB:  res = {h, l} - sa * sb;
      OP_MSUBU: res = {h, l} - ua * ub;
      default:  ok = 1'b0;
    endcase
  endfunction

  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  logic        m_pok = 1'b0;
  int          m_left = 0;

  always @(posedge clk or negedge reset_n) begin
    logic [63:0] r;
    logic        ok;
    if (!reset_n) begin
      m_hi <= '0; m_lo <= '0; m_phi <= '0; m_plo <= '0; m_pok <= 1'b0; m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && m_pok) begin
        m_hi <= m_phi;
        m_lo <= m_plo;
      end
    end else if (!req && model_starts(md_op)) begin
      model_op(md_op, rs_val, rt_val, m_hi, m_lo, r, ok);
      m_phi  <= r[63:32];
      m_plo  <= r[31:0];
      m_pok  <= ok;
      m_left <= (md_op == OP_DIV || md_op == OP_DIVU) ? int'(DIV_N) : int'(MULT_N);
    end else if (!req && md_op == OP_MTHI) begin
      m_hi <= rs_val;
    end else if (!req && md_op == OP_MTLO) begin
      m_lo <= rs_val;
    end
  end

  always @(negedge clk) begin
    logic [31:0] emf;
    emf = (md_op == OP_MFHI) ? m_hi : (md_op == OP_MFLO) ? m_lo : 32'h0;
    chk("cyc_start", {63'b0, start}, {63'b0, model_starts(md_op) && !req && (m_left == 0)});
    chk("cyc_busy",  {63'b0, busy},  {63'b0, m_left != 0});
    chk("cyc_hi",    {32'b0, hi},    {32'b0, m_hi});
    chk("cyc_lo",    {32'b0, lo},    {32'b0, m_lo});
    chk("cyc_mf",    {32'b0, mf_result}, {32'b0, emf});
  end

  // ---------------- stimulus helpers ----------------
  logic        last_start;
  logic [31:0] last_mf;

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq);
    md_op = op; rs_val = a; rt_val = b; req = rq;
    #1;
    last_start = start;
    last_mf    = mf_result;
    @(posedge clk); #1;
    md_op = OP_NONE; req = 1'b0;
  endtask

  // Counts busy cycles until idle; bounded so a stuck busy still ends the run.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    if (busy) chk("wait_idle_timeout", {63'b0, busy}, 64'h0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [63:0] r;
    logic ok;

    // Model pins: hand-computed results of the model's arithmetic.
    model_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, r, ok);
    chk("pin_div_ovf", r, 64'h0000_0000_8000_0000);
    model_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, '0, '0, r, ok);
    chk("pin_div_7_m2", r, 64'h0000_0001_FFFF_FFFD);
    model_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0, r, ok);
    chk("pin_multu_max", r, 64'hFFFF_FFFE_0000_0001);
    model_op(OP_DIVU, 32'd5, 32'd0, '0, '0, r, ok);
    chk("pin_div0_ok", {63'b0, ok}, 64'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {63'b0, busy}, 64'h0);
    chk("reset_hilo", {hi, lo}, 64'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1. mult / multu
    drive(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("t1_start", {63'b0, last_start}, 64'h1);
    wait_idle(n);
    chk("t1_busy_cycles", 64'(n), 64'd5);
    chk("t1_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    drive(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_idle(n);
    chk("t1_multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    // 2. div / divu
    drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("t2_hold_during_busy", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    wait_idle(n);
    chk("t2_busy_cycles", 64'(n), 64'd10);
    chk("t2_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    drive(OP_DIVU, 32'd7, 32'd2, 1'b0);
    wait_idle(n);
    chk("t2_divu", {hi, lo}, 64'h0000_0001_0000_0003);

    // 3. mthi/mtlo then divide by zero
    drive(OP_MTHI, 32'h1111_1111, 32'h0, 1'b0);
    drive(OP_MTLO, 32'h2222_2222, 32'h0, 1'b0);
    drive(OP_DIV, 32'd5, 32'd0, 1'b0);
    wait_idle(n);
    chk("t3_div0_busy", 64'(n), 64'd10);
    chk("t3_div0_hilo", {hi, lo}, 64'h1111_1111_2222_2222);
    drive(OP_MFHI, 32'h0, 32'h0, 1'b0);
    chk("t3_mfhi", {32'b0, last_mf}, 64'h1111_1111);
    drive(OP_MFLO, 32'h0, 32'h0, 1'b0);
    chk("t3_mflo", {32'b0, last_mf}, 64'h2222_2222);

    // 4. req flushes a start; req during flight does not
    drive(OP_MULT, 32'd3, 32'd5, 1'b1);
    chk("t4_req_start", {63'b0, last_start}, 64'h0);
    chk("t4_req_busy", {63'b0, busy}, 64'h0);
    drive(OP_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b1);
    chk("t4_req_hilo", {hi, lo}, 64'h1111_1111_2222_2222);
    drive(OP_MULT, 32'd3, 32'd5, 1'b0);
    drive(OP_NONE, 32'h0, 32'h0, 1'b1);
    wait_idle(n);
    chk("t4_inflight_busy", 64'(n), 64'd4);
    chk("t4_inflight_hilo", {hi, lo}, 64'h0000_0000_0000_000F);

    // 5. async reset in the middle of a divide
    drive(OP_MTHI, 32'hAAAA_5555, 32'h0, 1'b0);
    drive(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (3) @(posedge clk);
    #4;
    reset_n = 1'b0;
    #1;
    chk("t5_reset_busy", {63'b0, busy}, 64'h0);
    chk("t5_reset_hilo", {hi, lo}, 64'h0);
    #3;
    reset_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("t5_no_commit", {hi, lo}, 64'h0);
    chk("t5_idle", {63'b0, busy}, 64'h0);

    // 6. accumulate opcodes
`ifdef MDU_MADD_EN
    drive(OP_MTLO, 32'd1, 32'h0, 1'b0);
    drive(OP_MADD, 32'd3, 32'd4, 1'b0);
    wait_idle(n);
    chk("t6_madd_busy", 64'(n), 64'd5);
    chk("t6_madd", {hi, lo}, 64'h0000_0000_0000_000D);
    drive(OP_MTLO, 32'd0, 32'h0, 1'b0);
    drive(OP_MSUBU, 32'd1, 32'd2, 1'b0);
    wait_idle(n);
    chk("t6_msubu", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
`else
    drive(OP_MTLO, 32'd1, 32'h0, 1'b0);
    drive(OP_MADD, 32'd3, 32'd4, 1'b0);
    chk("t6_madd_disabled_start", {63'b0, last_start}, 64'h0);
    chk("t6_madd_disabled_busy", {63'b0, busy}, 64'h0);
    chk("t6_madd_disabled_hilo", {hi, lo}, 64'h0000_0000_0000_0001);
`endif

    // Random phase: every opcode, corner operands, occasional req.
    for (int i = 0; i < 3000; i++) begin
      md_op  = 4'($urandom_range(0, 12));
      rs_val = pick_val();
      rt_val = pick_val();
      req    = ($urandom_range(0, 9) == 0);
      @(posedge clk); #1;
    end
    md_op = OP_NONE;
    req   = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
